// File: rtl/mul_bf16_issue_collect_if.sv
// Operand / result stream bundle between the bf16 issue-collect block, its
// producer, the strobe-only multiplier and the downstream result consumer.
interface mul_bf16_issue_collect_if;
  logic [31:0] op_in;
  logic        op_in_valid;
  logic        op_in_ready;
  logic [31:0] mul_operand;
  logic        mul_operand_stb;
  logic [15:0] mul_z;
  logic        mul_z_stb;
  logic [15:0] res_out;
  logic        res_valid;
  logic        res_ready;

  modport slave (
    input  op_in, op_in_valid, mul_z, mul_z_stb, res_ready,
    output op_in_ready, mul_operand, mul_operand_stb, res_out, res_valid
  );

  modport master (
    output op_in, op_in_valid, mul_z, mul_z_stb, res_ready,
    input  op_in_ready, mul_operand, mul_operand_stb, res_out, res_valid
  );
endinterface

// File: rtl/mul_bf16_issue_collect.sv
// Credit-gated issuer/collector around a fixed-latency, stall-free bf16 multiplier.
// Optional issue-to-result latency checker: define MUL_ISSUE_LAT_CHECK_EN.
module mul_bf16_issue_collect #(
  parameter int MUL_LATENCY = 2,
  parameter int FIFO_DEPTH  = 8,
  parameter int CNT_W       = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mul_bf16_issue_collect_if.slave bus,
  output logic [CNT_W-1:0]      inflight,
  output logic [CNT_W-1:0]      res_count,
  output logic                  lat_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic signed [CNT_W:0] DEPTH_S = (CNT_W+1)'(FIFO_DEPTH);

  logic [31:0]         r_operand;
  logic                r_operand_stb;
  logic [CNT_W-1:0]    r_inflight;
  logic [CNT_W-1:0]    r_res_count;
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [15:0]         r_mem [FIFO_DEPTH];

  logic signed [CNT_W:0] w_credit;
  logic                w_credit_ok;
  logic                w_accept;
  logic                w_push;
  logic                w_pop;
  logic                w_res_valid;

  // Every issued operand reserves a FIFO slot, so a result can always land.
  assign w_credit    = DEPTH_S - signed'({1'b0, r_res_count}) - signed'({1'b0, r_inflight});
  assign w_credit_ok = !w_credit[CNT_W] && (w_credit != '0);

  assign w_accept    = bus.op_in_valid && bus.op_in_ready;
  assign w_push      = bus.mul_z_stb && (r_inflight != '0);
  assign w_res_valid = (r_res_count != '0);
  assign w_pop       = w_res_valid && bus.res_ready;

  assign bus.op_in_ready     = w_credit_ok && rst_n;
  assign bus.mul_operand     = r_operand;
  assign bus.mul_operand_stb = r_operand_stb;
  assign bus.res_valid       = w_res_valid;
  assign bus.res_out         = w_res_valid ? r_mem[r_rd_ptr] : 16'h0000;
  assign inflight            = r_inflight;
  assign res_count           = r_res_count;

  // Issue stage and occupancy counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_operand     <= '0;
      r_operand_stb <= 1'b0;
      r_inflight    <= '0;
      r_res_count   <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
    end else begin
      r_operand_stb <= w_accept;
      if (w_accept) r_operand <= bus.op_in;

      case ({w_accept, w_push})
        2'b10:   r_inflight <= r_inflight + CNT_W'(1);
        2'b01:   r_inflight <= r_inflight - CNT_W'(1);
        default: r_inflight <= r_inflight;
      endcase

      case ({w_push, w_pop})
        2'b10:   r_res_count <= r_res_count + CNT_W'(1);
        2'b01:   r_res_count <= r_res_count - CNT_W'(1);
        default: r_res_count <= r_res_count;
      endcase

      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
    end
  end

  // Result storage carries no reset; emptiness is tracked by the count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.mul_z;
  end

`ifdef MUL_ISSUE_LAT_CHECK_EN
  logic [MUL_LATENCY-1:0] r_lat_sr;
  logic                   r_lat_err;

  // Oldest bit marks the cycle a result is due back from the multiplier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lat_sr  <= '0;
      r_lat_err <= 1'b0;
    end else begin
      r_lat_sr <= MUL_LATENCY'({r_lat_sr, r_operand_stb});
      if ((bus.mul_z_stb != r_lat_sr[MUL_LATENCY-1]) ||
          (bus.mul_z_stb && (r_inflight == '0)))
        r_lat_err <= 1'b1;
    end
  end

  assign lat_err = r_lat_err;
`else
  assign lat_err = 1'b0;
`endif

endmodule
